// File: rtl/mar_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mar_mem_responder_pkg
// Shared definitions for the MAR memory responder:
//   - default data/address widths of the simple CPU datapath
//   - wait-state counter width (WAIT_STATES is limited to 0..15)
//   - responder FSM state encoding and the datapath word type
// -----------------------------------------------------------------------------
package mar_mem_responder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/mar_mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mar_mem_responder_mem_array
// Single-port word RAM: synchronous write, combinational read of the addressed
// word. Contents are not reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable for this edge
//   addr   in   word index ($clog2(DEPTH) bits)
//   wdata  in   data written when we=1
//   rdata  out  current contents of mem[addr]
// -----------------------------------------------------------------------------
module mar_mem_responder_mem_array
    import mar_mem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mar_mem_responder.sv
// -----------------------------------------------------------------------------
// mar_mem_responder
// Word-addressed memory at the far end of the MAR address path. A request is
// accepted in IDLE, WAIT_STATES wait cycles follow, then the access happens on
// the edge entering RESP and ack pulses for the single RESP cycle.
// Optional feature macro: MEM_RANGE_CHK_EN (addresses >= DEPTH flag err, the
// write is suppressed and a read returns 0). Without it, addresses alias
// modulo DEPTH and err is tied 0.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   req      in   request strobe, sampled only in IDLE
//   we       in   1 = write, 0 = read, sampled with req
//   addr_in  in   word address from MAR
//   wdata    in   write data, sampled with req
//   rdata    out  registered read data, held until the next completed read
//   ack      out  one-cycle completion pulse
//   busy     out  high while a transaction is in flight
//   err      out  range error, valid with ack
// -----------------------------------------------------------------------------
module mar_mem_responder
    import mar_mem_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              access;
    logic              in_range;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_hi;

    // With zero wait states the access edge is the acceptance edge itself,
    // so the access must use the live inputs rather than the latches.
    assign acc_addr  = (state_q == IDLE) ? addr_in : addr_q;
    assign acc_we    = (state_q == IDLE) ? we      : we_q;
    assign acc_wdata = (state_q == IDLE) ? wdata   : wdata_q;

    // Upper address bits only matter to the range check.
    assign unused_addr_hi = ^acc_addr;

`ifdef MEM_RANGE_CHK_EN
    assign in_range = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr_in;
                    we_d    = we;
                    wdata_d = wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (access && !acc_we) begin
            rdata_d = in_range ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request latches carry data only; their reset value is irrelevant.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    mar_mem_responder_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (access && acc_we && in_range),
        .addr  (acc_addr[IDX_W-1:0]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

`ifdef MEM_RANGE_CHK_EN
    logic err_q, err_d;

    // Registered on the access edge so it is high only in the RESP cycle.
    assign err_d = access && !in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdata = rdata_q;
    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mar_mem_responder.sv
module tb_mar_mem_responder;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int DEPTH       = 256;
    localparam int WAIT_STATES = 2;
    localparam int LAT         = WAIT_STATES + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: word store plus the last value returned by a read.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_rdata;

    // Observations of the most recent transaction.
    int                obs_lat;
    int                obs_busy;
    logic [DATA_W-1:0] obs_rdata;
    logic              obs_err;
    logic              obs_ack_after;
    logic              obs_busy_after;

    mar_mem_responder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr_in (addr_in),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic model_in_range(input logic [ADDR_W-1:0] a);
`ifdef MEM_RANGE_CHK_EN
        return (int'(a) < DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    // Expected rdata after a transaction; also updates the model.
    function automatic logic [DATA_W-1:0] model_apply(input logic w, input logic [ADDR_W-1:0] a,
                                                      input logic [DATA_W-1:0] d);
        if (w) begin
            if (model_in_range(a)) model_mem[int'(a) % DEPTH] = d;
        end else begin
            model_rdata = model_in_range(a) ? model_mem[int'(a) % DEPTH] : '0;
        end
        return model_rdata;
    endfunction

    // Issue one request, scramble the inputs during the wait, observe ack.
    task automatic run_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W-1:0] g_addr, input logic [DATA_W-1:0] g_data);
        @(negedge clk);
        req = 1'b1; we = w; addr_in = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; addr_in = g_addr; wdata = g_data;
        obs_lat = 0; obs_busy = 0; obs_rdata = '0; obs_err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (busy) obs_busy++;
            if (ack) begin
                obs_lat = n; obs_rdata = rdata; obs_err = err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        obs_ack_after = ack;
        obs_busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b1; we = 1'b0; addr_in = '0; wdata = '0;
        #1;
        vectors++;
        if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_async: ack=%b busy=%b err=%b rdata=%h, want 0 0 0 0000", ack, busy, err, rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held: ack=%b busy=%b err=%b rdata=%h, want 0 0 0 0000", ack, busy, err, rdata);
        end
        req = 1'b0;
        reset = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_fill();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] d = DATA_W'($urandom);
            logic [DATA_W-1:0] exp = model_apply(1'b1, ADDR_W'(i), d);
            run_txn(1'b1, ADDR_W'(i), d, ADDR_W'($urandom), DATA_W'($urandom));
            if (obs_lat != LAT || obs_rdata !== exp) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL fill_writes: %0d bad writes, want 0", bad);
        end
    endtask

    task automatic test_beef();
        logic [DATA_W-1:0] exp;
        exp = model_apply(1'b1, 16'h0010, 16'hBEEF);
        run_txn(1'b1, 16'h0010, 16'hBEEF, 16'h0011, 16'h0000);
        vectors++;
        if (obs_lat != LAT || obs_busy != LAT) begin
            miscompares++;
            $display("FAIL beef_write_timing: lat=%0d busy=%0d, want %0d %0d", obs_lat, obs_busy, LAT, LAT);
        end
        vectors++;
        if (obs_rdata !== exp) begin
            miscompares++;
            $display("FAIL beef_write_rdata_hold: rdata=%h, want %h", obs_rdata, exp);
        end
        vectors++;
        if (obs_ack_after !== 1'b0 || obs_busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL beef_write_pulse: ack=%b busy=%b after RESP, want 0 0", obs_ack_after, obs_busy_after);
        end
        exp = model_apply(1'b0, 16'h0010, '0);
        run_txn(1'b0, 16'h0010, 16'h0000, 16'h0011, 16'h1234);
        vectors++;
        if (obs_lat != LAT || obs_busy != LAT || obs_rdata !== 16'hBEEF || exp !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL beef_read: lat=%0d busy=%0d rdata=%h, want %0d %0d BEEF", obs_lat, obs_busy, obs_rdata, LAT, LAT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic              w = 1'($urandom_range(0, 1));
            logic [ADDR_W-1:0] a = ADDR_W'($urandom);
            logic [DATA_W-1:0] d = DATA_W'($urandom);
            logic [DATA_W-1:0] exp = model_apply(w, a, d);
            logic              exp_err = ~model_in_range(a);
            run_txn(w, a, d, ADDR_W'($urandom), DATA_W'($urandom));
            vectors++;
            if (obs_lat != LAT || obs_rdata !== exp || obs_err !== exp_err) begin
                miscompares++;
                $display("FAIL random_%0d: we=%b addr=%h lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                         i, w, a, obs_lat, obs_rdata, obs_err, LAT, exp, exp_err);
            end
        end
    endtask

    task automatic test_late_change();
        logic [DATA_W-1:0] exp;
        void'(model_apply(1'b1, 16'h0020, 16'hAAAA));
        run_txn(1'b1, 16'h0020, 16'hAAAA, 16'h0021, 16'h5A5A);
        exp = model_apply(1'b0, 16'h0020, '0);
        run_txn(1'b0, 16'h0020, '0, 16'h0021, '0);
        vectors++;
        if (obs_rdata !== exp || exp !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL late_change_target: rdata=%h, want AAAA", obs_rdata);
        end
        exp = model_apply(1'b0, 16'h0021, '0);
        run_txn(1'b0, 16'h0021, '0, 16'h0020, '0);
        vectors++;
        if (obs_rdata !== exp) begin
            miscompares++;
            $display("FAIL late_change_neighbour: rdata=%h, want %h", obs_rdata, exp);
        end
    endtask

    task automatic test_back_to_back();
        int               ack_cyc [4];
        logic [DATA_W-1:0] ack_dat [4];
        int               acks = 0;
        int               idx = 0;
        int               extra = 0;
        logic             prev_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            void'(model_apply(1'b1, ADDR_W'(i), DATA_W'(16'h1111 * (i + 1))));
            run_txn(1'b1, ADDR_W'(i), DATA_W'(16'h1111 * (i + 1)), ADDR_W'($urandom), DATA_W'($urandom));
        end
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr_in = '0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc[acks] = c; ack_dat[acks] = rdata; acks++;
            end
            if (busy && !prev_busy) begin
                idx++;
                if (idx < 4) addr_in = ADDR_W'(idx);
                else req = 1'b0;
            end
            prev_busy = busy;
        end
        req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack) extra++;
        end
        vectors++;
        if (acks != 4 || extra != 0) begin
            miscompares++;
            $display("FAIL b2b_ack_count: acks=%0d extra=%0d, want 4 0", acks, extra);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < acks) begin
                vectors++;
                if (ack_dat[i] !== model_mem[i] || (i > 0 && ack_cyc[i] - ack_cyc[i-1] != WAIT_STATES + 2)) begin
                    miscompares++;
                    $display("FAIL b2b_read_%0d: rdata=%h gap=%0d, want %h %0d", i, ack_dat[i],
                             (i > 0) ? ack_cyc[i] - ack_cyc[i-1] : 0, model_mem[i], WAIT_STATES + 2);
                end
            end
        end
        model_rdata = model_mem[3];
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] exp;
        int               seen = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr_in = 16'h0030; wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: busy=%b ack=%b rdata=%h, want 0 0 0000", busy, ack, rdata);
        end
        #1 reset = 1'b0;
        model_rdata = '0;
        repeat (8) begin
            @(negedge clk);
            if (ack || busy) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_ack: %0d active cycles, want 0", seen);
        end
        exp = model_apply(1'b0, 16'h0030, '0);
        run_txn(1'b0, 16'h0030, '0, 16'h0030, 16'h5555);
        vectors++;
        if (obs_rdata !== exp || obs_lat != LAT) begin
            miscompares++;
            $display("FAIL reset_mid_mem: rdata=%h lat=%0d, want %h %0d", obs_rdata, obs_lat, exp, LAT);
        end
    endtask

    task automatic test_range();
        logic [DATA_W-1:0] exp;
        logic              exp_err = ~model_in_range(16'h0110);
        exp = model_apply(1'b1, 16'h0110, 16'h1234);
        run_txn(1'b1, 16'h0110, 16'h1234, 16'h0010, 16'hFFFF);
        vectors++;
        if (obs_lat != LAT || obs_err !== exp_err || obs_rdata !== exp) begin
            miscompares++;
            $display("FAIL range_write: lat=%0d err=%b rdata=%h, want %0d %b %h", obs_lat, obs_err, obs_rdata, LAT, exp_err, exp);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL range_err_clear: err=%b after RESP, want 0", err);
        end
        exp = model_apply(1'b0, 16'h0010, '0);
        run_txn(1'b0, 16'h0010, '0, 16'h0110, '0);
        vectors++;
        if (obs_rdata !== exp || obs_err !== 1'b0) begin
            miscompares++;
            $display("FAIL range_alias_read: rdata=%h err=%b, want %h 0", obs_rdata, obs_err, exp);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_beef();
        test_random();
        test_late_change();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
